gate_bist_sequencer: RTL and testbench
======================================

Name: gate_bist_sequencer

Overview:
- Built-in self-test sequencer for the two-input gate bank (OR, NOT, NAND, NOR, XNOR, XOR).
- Drives the shared a/b stimulus pair through a fixed Gray-order vector walk and waits a programmable settle time per vector.
- Compares all six gate outputs against an internal reference and reports pass/fail, an error count and a sticky per-gate failure mask.
- Sits between the test-control register and the gate bank; it is the only driver of a/b during a run.

Parameters:
- SETTLE_CYCLES, 2, cycles a/b are held before outputs are checked; legal range 1..15.
- LOOPS, 1, number of complete 4-vector walks per run; legal range 1..255.
- CNT_W, 8, width of err_count.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle run request; honoured only in IDLE
- abort  input  1  synchronous abort; returns to IDLE
- gate_out  input  6  DUT outputs; [0]=OR [1]=NOT [2]=NAND [3]=NOR [4]=XNOR [5]=XOR
- a  output  1  stimulus A (registered)
- b  output  1  stimulus B (registered)
- busy  output  1  high from the cycle after start until done or abort
- done  output  1  one-cycle pulse when a run completes
- pass  output  1  result of the last completed run; held until the next start
- err_count  output  CNT_W  mismatching gate-samples in the current/last run; saturating
- fail_mask  output  6  sticky OR of per-gate mismatches in the current/last run

Behaviour:
- Reset (async assert, sync release): state=IDLE; a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0.
- Vector order {a,b}: 00, 10, 11, 01 (index 0..3), repeated LOOPS times.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - a=b=0.
  - On start in cycle T0: load vector 0 into a/b, set settle counter=SETTLE_CYCLES, clear err_count/fail_mask/pass, set busy.
  - From T0+1: state=SETTLE.
- SETTLE:
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to CHECK the next cycle.
- CHECK (one cycle):
  - Expected values: OR=a|b, NOT=~a, NAND=~(a&b), NOR=~(a|b), XNOR=~(a^b), XOR=a^b.
  - mismatch = gate_out ^ expected.
  - fail_mask |= mismatch.
  - err_count += popcount(mismatch), saturating at 2^CNT_W-1.
  - If this was the last vector of the last loop: go to DONE. Otherwise load the next vector into a/b, reload the counter, return to SETTLE. Vector index wraps 3->0 and increments the loop counter.
- DONE (one cycle):
  - done=1, busy=0.
  - pass=1 iff fail_mask==0, including the final CHECK's contribution.
  - a=b=0; next state IDLE.
- Latency: each vector occupies SETTLE_CYCLES+1 cycles. done is high in cycle T0+1+LOOPS*4*(SETTLE_CYCLES+1).
- start while busy or in DONE: ignored.
- abort:
  - Priority over start and over CHECK in the same cycle.
  - Any non-IDLE state -> IDLE next cycle: busy=0, a=b=0, pass=0, no done pulse.
  - err_count and fail_mask retain partial values.
- abort in IDLE: no effect.
- rst_n low mid-run: immediate reset values; the run is lost.
- gate_out is sampled only in CHECK; X/Z on gate_out counts as a mismatch.

Optional Feature:
- Macro: GATE_BIST_FIRST_FAIL_EN.
- Defined:
  - Adds outputs first_fail_vec (2 bits) and first_fail_loop (8 bits), plus first_fail_valid (1 bit).
  - These latch the vector index and loop of the first CHECK with a nonzero mismatch.
  - Cleared on start and on reset; held through DONE and IDLE.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package gate_bist_pkg:
  - state enum (IDLE, SETTLE, CHECK, DONE)
  - gate bit-index constants GATE_OR..GATE_XOR
  - 4-entry vector table constant
  - NUM_GATES=6
- Sub-module gate_bist_ref: purely combinational; a, b -> 6-bit expected vector. It is reused by the bench scoreboard.

Test Plan:
- Correct dataflow gate bank, SETTLE_CYCLES=1, LOOPS=1: start at T0 -> a/b sequence 00,10,11,01 at two-cycle spacing; done at T0+9; pass=1, err_count=0, fail_mask=0.
- NAND output forced to 1, LOOPS=2: fails only on vector 11 -> err_count=2, fail_mask=6'b000100, pass=0.
- All six outputs inverted, CNT_W=3, LOOPS=2: 48 mismatches -> err_count saturates at 7, fail_mask=6'b111111.
- abort during vector 2 SETTLE: busy=0 and a=b=0 next cycle; no done pulse; pass=0. A subsequent start runs a full clean pass.
- rst_n pulsed low mid-CHECK: outputs go to reset values asynchronously. start pulsed during busy -> ignored; done timing unchanged.
- With GATE_BIST_FIRST_FAIL_EN and XOR stuck at 0, LOOPS=1: first_fail_valid=1, first_fail_vec=1 (vector 10), first_fail_loop=0.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// rtl/gate_bist_pkg.sv - shared types and constants for the gate-bank BIST sequencer
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int NUM_GATES = 6;
  localparam int GATE_OR   = 0;
  localparam int GATE_NOT  = 1;
  localparam int GATE_NAND = 2;
  localparam int GATE_NOR  = 3;
  localparam int GATE_XNOR = 4;
  localparam int GATE_XOR  = 5;

  // Gray walk of {a,b}: entry 0 in the low bits -> 00, 10, 11, 01
  localparam logic [7:0] VEC_TABLE = 8'b01_11_10_00;

  function automatic logic [1:0] vec_ab(input logic [1:0] idx);
    return VEC_TABLE[{idx, 1'b0} +: 2];
  endfunction

  function automatic logic [2:0] popcount6(input logic [NUM_GATES-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_GATES; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/gate_bist_ref.sv
// rtl/gate_bist_ref.sv - combinational reference model of the six-gate bank
module gate_bist_ref
  import gate_bist_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] expected
);

  always_comb begin
    expected            = '0;
    expected[GATE_OR]   = a | b;
    expected[GATE_NOT]  = ~a;
    expected[GATE_NAND] = ~(a & b);
    expected[GATE_NOR]  = ~(a | b);
    expected[GATE_XNOR] = ~(a ^ b);
    expected[GATE_XOR]  = a ^ b;
  end

endmodule

// File: rtl/gate_bist_sequencer.sv
// rtl/gate_bist_sequencer.sv - BIST sequencer walking a/b through the gate bank and scoring outputs
// Optional first-failure capture ports enabled by GATE_BIST_FIRST_FAIL_EN.
module gate_bist_sequencer
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_GATES-1:0] gate_out,
  output logic                 a,
  output logic                 b,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     err_count,
`ifdef GATE_BIST_FIRST_FAIL_EN
  output logic [1:0]           first_fail_vec,
  output logic [7:0]           first_fail_loop,
  output logic                 first_fail_valid,
`endif
  output logic [NUM_GATES-1:0] fail_mask
);

  localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

  state_e               state_q, state_d;
  logic                 a_q, a_d, b_q, b_d, pass_q, pass_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [1:0]           vec_q, vec_d;
  logic [7:0]           loop_q, loop_d;
  logic [CNT_W-1:0]     err_q, err_d;
  logic [NUM_GATES-1:0] mask_q, mask_d;
  logic [NUM_GATES-1:0] expected, mismatch;
  logic [CNT_W+2:0]     err_sum;
  logic                 last_vec, start_ok;
`ifdef GATE_BIST_FIRST_FAIL_EN
  logic [1:0]           ffv_q, ffv_d;
  logic [7:0]           ffl_q, ffl_d;
  logic                 ffok_q, ffok_d;
`endif

  gate_bist_ref u_ref (
    .a        (a_q),
    .b        (b_q),
    .expected (expected)
  );

  // Case-equality so an X/Z from the bank scores as a mismatch
  always_comb begin
    mismatch = '0;
    for (int i = 0; i < NUM_GATES; i++) mismatch[i] = (gate_out[i] === expected[i]) ? 1'b0 : 1'b1;
  end

  assign err_sum  = (CNT_W+3)'(err_q) + (CNT_W+3)'(popcount6(mismatch));
  assign last_vec = (vec_q == 2'd3) && (loop_q == 8'(LOOPS - 1));
  assign start_ok = start && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      pass_q  <= 1'b0;
      cnt_q   <= '0;
      vec_q   <= '0;
      loop_q  <= '0;
      err_q   <= '0;
      mask_q  <= '0;
`ifdef GATE_BIST_FIRST_FAIL_EN
      ffv_q   <= '0;
      ffl_q   <= '0;
      ffok_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      loop_q  <= loop_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
`ifdef GATE_BIST_FIRST_FAIL_EN
      ffv_q   <= ffv_d;
      ffl_q   <= ffl_d;
      ffok_q  <= ffok_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = SETTLE;
      SETTLE:  if (abort) state_d = IDLE; else if (cnt_q == 4'd1) state_d = CHECK;
      CHECK:   if (abort) state_d = IDLE; else state_d = last_vec ? DONE : SETTLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    pass_d = pass_q;
    cnt_d  = cnt_q;
    vec_d  = vec_q;
    loop_d = loop_q;
    err_d  = err_q;
    mask_d = mask_q;
`ifdef GATE_BIST_FIRST_FAIL_EN
    ffv_d  = ffv_q;
    ffl_d  = ffl_q;
    ffok_d = ffok_q;
`endif
    if (state_q != IDLE && abort) begin
      a_d    = 1'b0;
      b_d    = 1'b0;
      pass_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          a_d = 1'b0;
          b_d = 1'b0;
          if (start_ok) begin
            {a_d, b_d} = vec_ab(2'd0);
            cnt_d  = 4'(SETTLE_CYCLES);
            vec_d  = '0;
            loop_d = '0;
            err_d  = '0;
            mask_d = '0;
            pass_d = 1'b0;
`ifdef GATE_BIST_FIRST_FAIL_EN
            ffv_d  = '0;
            ffl_d  = '0;
            ffok_d = 1'b0;
`endif
          end
        end
        SETTLE: cnt_d = cnt_q - 4'd1;
        CHECK: begin
          mask_d = mask_q | mismatch;
          err_d  = (err_sum > (CNT_W+3)'(ERR_MAX)) ? ERR_MAX : err_sum[CNT_W-1:0];
`ifdef GATE_BIST_FIRST_FAIL_EN
          if (!ffok_q && mismatch != '0) begin
            ffv_d  = vec_q;
            ffl_d  = loop_q;
            ffok_d = 1'b1;
          end
`endif
          if (last_vec) begin
            a_d    = 1'b0;
            b_d    = 1'b0;
            pass_d = ((mask_q | mismatch) == '0);
          end else begin
            vec_d      = vec_q + 2'd1;
            loop_d     = (vec_q == 2'd3) ? loop_q + 8'd1 : loop_q;
            {a_d, b_d} = vec_ab(vec_q + 2'd1);
            cnt_d      = 4'(SETTLE_CYCLES);
          end
        end
        default: begin
          a_d = 1'b0;
          b_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    busy      = (state_q == SETTLE) || (state_q == CHECK);
    done      = (state_q == DONE);
    a         = a_q;
    b         = b_q;
    pass      = pass_q;
    err_count = err_q;
    fail_mask = mask_q;
`ifdef GATE_BIST_FIRST_FAIL_EN
    first_fail_vec   = ffv_q;
    first_fail_loop  = ffl_q;
    first_fail_valid = ffok_q;
`endif
  end

endmodule

// File: tb/tb_gate_bist_sequencer.sv
// tb/tb_gate_bist_sequencer.sv - self-checking bench for gate_bist_sequencer with a faultable gate bank
module tb_gate_bist_sequencer;

  localparam int SC = 2;
  localparam int LP = 2;
  localparam int CW = 3;
  localparam int DONE_K = 1 + LP * 4 * (SC + 1);

  logic          clk = 1'b0;
  logic          rst_n, start, abort;
  logic [5:0]    gate_out;
  logic          a, b, busy, done, pass;
  logic [CW-1:0] err_count;
  logic [5:0]    fail_mask;
`ifdef GATE_BIST_FIRST_FAIL_EN
  logic [1:0]    first_fail_vec;
  logic [7:0]    first_fail_loop;
  logic          first_fail_valid;
`endif

  int checks = 0;
  int failures = 0;
  int fault = 0;
  logic [1:0] sb_q[$];
  logic       prev_busy = 1'b0;
  logic [1:0] last_ab = 2'b00;

  gate_bist_sequencer #(.SETTLE_CYCLES(SC), .LOOPS(LP), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_out(gate_out),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
`ifdef GATE_BIST_FIRST_FAIL_EN
    .first_fail_vec(first_fail_vec), .first_fail_loop(first_fail_loop),
    .first_fail_valid(first_fail_valid),
`endif
    .fail_mask(fail_mask)
  );

  always #5 clk = ~clk;

  // Bank model: 0 clean, 1 NAND stuck-1, 2 all inverted, 3 XOR stuck-0
  always_comb begin
    logic [5:0] g;
    g = {a ^ b, ~(a ^ b), ~(a | b), ~(a & b), ~a, a | b};
    case (fault)
      1:       g[2] = 1'b1;
      2:       g = ~g;
      3:       g[5] = 1'b0;
      default: ;
    endcase
    gate_out = g;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_walk(input int n);
    logic [7:0] tbl;
    tbl = 8'b01_11_10_00;
    for (int i = 0; i < n; i++) sb_q.push_back(tbl[(i % 4) * 2 +: 2]);
  endtask

  // Scoreboard: each new a/b value seen while busy must be the next expected vector
  always @(negedge clk) begin
    if (busy && (!prev_busy || {a, b} != last_ab)) begin
      if (sb_q.size() == 0) check("extra_vector", {30'd0, a, b}, 32'hFF);
      else check("ab_vector", {30'd0, a, b}, {30'd0, sb_q.pop_front()});
    end
    prev_busy <= busy;
    last_ab   <= {a, b};
  end

  // Leaves the bench just after posedge P1 with start released (cycle T0+1)
  task automatic kick(input int nvec);
    @(posedge clk); #1 start = 1'b1;
    push_walk(nvec);
    @(posedge clk); #1 start = 1'b0;
  endtask

  typedef struct {
    string      name;
    int         fault;
    bit         poke;
    logic [2:0] err;
    logic [5:0] mask;
    logic       pass;
    logic       ff_valid;
    logic [1:0] ff_vec;
  } case_t;

  case_t cases[5];

  initial begin
    int k;
    int seen;
    cases[0] = '{"clean",    0, 1'b0, 3'd0, 6'b000000, 1'b1, 1'b0, 2'd0};
    cases[1] = '{"nand_s1",  1, 1'b0, 3'd2, 6'b000100, 1'b0, 1'b1, 2'd2};
    cases[2] = '{"inverted", 2, 1'b0, 3'd7, 6'b111111, 1'b0, 1'b1, 2'd0};
    cases[3] = '{"xor_s0",   3, 1'b1, 3'd4, 6'b100000, 1'b0, 1'b1, 2'd1};
    cases[4] = '{"clean_pk", 0, 1'b1, 3'd0, 6'b000000, 1'b1, 1'b0, 2'd0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("rst_a", {31'd0, a}, 0);
    check("rst_b", {31'd0, b}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_pass", {31'd0, pass}, 0);
    check("rst_err", {29'd0, err_count}, 0);
    check("rst_mask", {26'd0, fail_mask}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int c = 0; c < 5; c++) begin
      fault = cases[c].fault;
      kick(4 * LP);
      k = 1;
      while (k <= 80) begin
        start = (cases[c].poke && k == 10);
        @(negedge clk);
        if (done) break;
        @(posedge clk); #1;
        k++;
      end
      start = 1'b0;
      check({cases[c].name, "_done_cycle"}, k, DONE_K);
      check({cases[c].name, "_err"}, {29'd0, err_count}, {29'd0, cases[c].err});
      check({cases[c].name, "_mask"}, {26'd0, fail_mask}, {26'd0, cases[c].mask});
      check({cases[c].name, "_pass"}, {31'd0, pass}, {31'd0, cases[c].pass});
      check({cases[c].name, "_sb_empty"}, sb_q.size(), 0);
`ifdef GATE_BIST_FIRST_FAIL_EN
      check({cases[c].name, "_ff_valid"}, {31'd0, first_fail_valid}, {31'd0, cases[c].ff_valid});
      if (cases[c].ff_valid) begin
        check({cases[c].name, "_ff_vec"}, {30'd0, first_fail_vec}, {30'd0, cases[c].ff_vec});
        check({cases[c].name, "_ff_loop"}, {24'd0, first_fail_loop}, 0);
      end
`endif
      sb_q.delete();
      @(posedge clk); #1;
      @(negedge clk);
      check({cases[c].name, "_idle_busy"}, {31'd0, busy}, 0);
      check({cases[c].name, "_idle_done"}, {31'd0, done}, 0);
      check({cases[c].name, "_idle_ab"}, {30'd0, a, b}, 0);
      check({cases[c].name, "_pass_held"}, {31'd0, pass}, {31'd0, cases[c].pass});
    end

    // Abort during the SETTLE of vector 2, with two inverted vectors already scored
    fault = 2;
    kick(3);
    repeat (6) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_ab", {30'd0, a, b}, 0);
    check("abort_pass", {31'd0, pass}, 0);
    check("abort_err_kept", {29'd0, err_count}, 7);
    check("abort_mask_kept", {26'd0, fail_mask}, 6'h3F);
    check("abort_sb_empty", sb_q.size(), 0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", seen, 0);
    sb_q.delete();

    fault = 0;
    kick(4 * LP);
    k = 1;
    while (k <= 80) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk); #1;
      k++;
    end
    check("rerun_done_cycle", k, DONE_K);
    check("rerun_pass", {31'd0, pass}, 1);
    check("rerun_err", {29'd0, err_count}, 0);
    sb_q.delete();

    // Asynchronous reset in the CHECK cycle of vector 1 (a=1, six errors so far)
    @(posedge clk); #1;
    fault = 2;
    kick(2);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_a", {31'd0, a}, 0);
    check("arst_busy", {31'd0, busy}, 0);
    check("arst_err", {29'd0, err_count}, 0);
    check("arst_mask", {26'd0, fail_mask}, 0);
    check("arst_sb_empty", sb_q.size(), 0);
    sb_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
